// File: rtl/apb_sb_pkg.sv
// Shared encodings for the parametrised APB south-bridge decoder/mux.
// Holds error-cause codes, FSM states and the default error read data.
package apb_sb_pkg;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_UNMAPPED = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_SLAVE    = 2'b11
  } err_cause_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } sb_state_e;

  localparam logic [31:0] SB_DEF_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/apb_sb_wdog.sv
// Per-transfer wait-state watchdog: counts stalled ACCESS cycles and flags
// expiry when the count reaches TIMEOUT (TIMEOUT = 0 never expires).
module apb_sb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic wait_i,
  output logic expire_o
);

  localparam int CNT_W = (TIMEOUT <= 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TC = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturate at the terminal count so a stalled master cannot wrap it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (wait_i && (cnt_q != TC)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (TIMEOUT != 0) && (cnt_q == TC);

endmodule

// File: rtl/apb_sb_mux.sv
// APB south-bridge decoder/mux: one master fanned out to NUM_SLOTS slaves with
// unmapped-slot errors, a wait-state watchdog, sticky error capture and IRQ masking.
//
// state  | meaning
// IDLE   | no transfer in flight; a setup phase may be on the bus this cycle
// SETUP  | setup phase captured; this cycle is the first access cycle
// ACCESS | later access cycles while the selected slave inserts wait states
module apb_sb_mux
  import apb_sb_pkg::*;
#(
  parameter int          NUM_SLOTS = 16,
  parameter int          SEL_W     = 4,
  parameter int          SEL_LSB   = 16,
  parameter logic [31:0] SLOT_EN   = 32'h0000_03FF,
  parameter logic [31:0] DEF_RDATA = SB_DEF_RDATA,
  parameter int          TIMEOUT   = 255
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [31:0]              PADDR,
  input  logic [31:0]              PWDATA,
  output logic [31:0]              PRDATA,
  output logic                     PREADY,
  output logic                     PSLVERR,
  output logic [NUM_SLOTS-1:0]     S_PSEL,
  output logic                     S_PENABLE,
  output logic                     S_PWRITE,
  output logic [31:0]              S_PADDR,
  output logic [31:0]              S_PWDATA,
  input  logic [32*NUM_SLOTS-1:0]  S_PRDATA,
  input  logic [NUM_SLOTS-1:0]     S_PREADY,
  input  logic [NUM_SLOTS-1:0]     S_PSLVERR,
  input  logic [NUM_SLOTS-1:0]     S_IRQ,
  output logic [NUM_SLOTS-1:0]     PIRQ,
  output logic                     ERR_VALID,
  output logic [1:0]               ERR_CAUSE,
  output logic                     ERR_WRITE,
  output logic [31:0]              ERR_ADDR,
  input  logic                     ERR_CLR
);

  sb_state_e            state_q, state_d;
  logic [SEL_W-1:0]     slot;
  logic [31:0]          slot_ext;
  logic                 hit;
  logic [NUM_SLOTS-1:0] slot_oh;
  logic [31:0]          sel_rdata;
  logic                 sel_ready, sel_err;
  logic                 acc, expire, timed_out, err_done;
  err_cause_e           cause;
  logic [NUM_SLOTS-1:0] pirq_q;
  logic                 err_valid_q, err_write_q;
  err_cause_e           err_cause_q;
  logic [31:0]          err_addr_q;

  assign slot     = PADDR[SEL_LSB +: SEL_W];
  assign slot_ext = 32'(slot);

  always_comb begin
    hit       = 1'b0;
    slot_oh   = '0;
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if ((slot_ext == 32'(i)) && SLOT_EN[i]) begin
        hit        = 1'b1;
        slot_oh[i] = 1'b1;
        sel_rdata  = S_PRDATA[32*i +: 32];
        sel_ready  = S_PREADY[i];
        sel_err    = S_PSLVERR[i];
      end
    end
  end

  assign acc = (state_q != IDLE) && PSEL;

  // A stray PENABLE while idle must not reach any slave.
  assign S_PSEL    = {NUM_SLOTS{PSEL && ((state_q != IDLE) || !PENABLE)}} & slot_oh;
  assign S_PENABLE = PENABLE;
  assign S_PWRITE  = PWRITE;
  assign S_PADDR   = PADDR;
  assign S_PWDATA  = PWDATA;

  apb_sb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk_i    (PCLK),
    .rst_i    (PRESET),
    .clear_i  (!acc),
    .wait_i   (acc && hit && !sel_ready),
    .expire_o (expire)
  );

  always_comb begin
    PREADY    = 1'b1;
    PSLVERR   = 1'b0;
    PRDATA    = '0;
    timed_out = 1'b0;
    if (acc) begin
      if (!hit) begin
        PSLVERR = 1'b1;
        PRDATA  = DEF_RDATA;
      end else if (!sel_ready && expire) begin
        PSLVERR   = 1'b1;
        PRDATA    = DEF_RDATA;
        timed_out = 1'b1;
      end else begin
        PREADY  = sel_ready;
        PSLVERR = sel_err;
        PRDATA  = sel_rdata;
      end
    end
  end

  assign err_done = acc && PREADY && PSLVERR;

  always_comb begin
    cause = ERR_SLAVE;
    if (!hit) begin
      cause = ERR_UNMAPPED;
    end else if (timed_out) begin
      cause = ERR_TIMEOUT;
    end
  end

  // Completion always returns to IDLE; a back-to-back setup is picked up there.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (PSEL && !PENABLE) state_d = SETUP;
      SETUP, ACCESS: state_d = (!PSEL || PREADY) ? IDLE : ACCESS;
      default:       state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= IDLE;
      pirq_q      <= '0;
      err_valid_q <= 1'b0;
      err_cause_q <= ERR_NONE;
      err_write_q <= 1'b0;
      err_addr_q  <= '0;
    end else begin
      state_q <= state_d;
      pirq_q  <= S_IRQ & SLOT_EN[NUM_SLOTS-1:0];
      if (err_done && (!err_valid_q || ERR_CLR)) begin
        err_valid_q <= 1'b1;
        err_cause_q <= cause;
        err_write_q <= PWRITE;
        err_addr_q  <= PADDR;
      end else if (ERR_CLR) begin
        err_valid_q <= 1'b0;
        err_cause_q <= ERR_NONE;
        err_write_q <= 1'b0;
        err_addr_q  <= '0;
      end
    end
  end

  assign PIRQ      = pirq_q;
  assign ERR_VALID = err_valid_q;
  assign ERR_CAUSE = err_cause_q;
  assign ERR_WRITE = err_write_q;
  assign ERR_ADDR  = err_addr_q;

endmodule

// File: tb/tb_apb_sb_mux.sv
// Scoreboarded bench for apb_sb_mux (TIMEOUT=4): a driver pushes expected
// completions and a negedge monitor pops and compares them.
module tb_apb_sb_mux;

  localparam int          NS   = 16;
  localparam int          TO   = 4;
  localparam logic [31:0] DEF  = 32'hDEAD_BEEF;
  localparam logic [31:0] SLEN = 32'h0000_03FF;

  logic           PCLK, PRESET, PSEL, PENABLE, PWRITE;
  logic [31:0]    PADDR, PWDATA, PRDATA;
  logic           PREADY, PSLVERR;
  logic [NS-1:0]  S_PSEL;
  logic           S_PENABLE, S_PWRITE;
  logic [31:0]    S_PADDR, S_PWDATA;
  logic [32*NS-1:0] S_PRDATA;
  logic [NS-1:0]  S_PREADY, S_PSLVERR, S_IRQ, PIRQ;
  logic           ERR_VALID, ERR_WRITE, ERR_CLR;
  logic [1:0]     ERR_CAUSE;
  logic [31:0]    ERR_ADDR;

  apb_sb_mux #(.TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .S_PSEL(S_PSEL), .S_PENABLE(S_PENABLE), .S_PWRITE(S_PWRITE), .S_PADDR(S_PADDR),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .S_IRQ(S_IRQ), .PIRQ(PIRQ), .ERR_VALID(ERR_VALID), .ERR_CAUSE(ERR_CAUSE),
    .ERR_WRITE(ERR_WRITE), .ERR_ADDR(ERR_ADDR), .ERR_CLR(ERR_CLR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [NS-1:0] psel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: mid-cycle sampling of completions against the scoreboard.
  logic in_xfer = 1'b0;
  int   acc_n   = 0;
  always @(negedge PCLK) begin
    exp_t e;
    if (PRESET) begin
      in_xfer = 1'b0;
      acc_n   = 0;
    end else if (PSEL && !PENABLE) begin
      in_xfer = 1'b1;
      acc_n   = 0;
    end else if (in_xfer && PSEL && PENABLE) begin
      if (PREADY) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_unexpected", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check_eq("prdata",   PRDATA,   e.rdata);
          check_eq("pslverr",  PSLVERR,  e.err);
          check_eq("latency",  acc_n,    e.lat);
          check_eq("s_psel",   S_PSEL,   e.psel);
          check_eq("s_pwrite", S_PWRITE, e.wr);
          check_eq("s_paddr",  S_PADDR,  e.addr);
          check_eq("s_pwdata", S_PWDATA, e.wdata);
        end
        in_xfer = 1'b0;
      end else begin
        acc_n++;
      end
    end else begin
      in_xfer = 1'b0;
    end
  end

  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input logic [31:0] srdata, input logic serr,
                         input logic clr_at_done);
    exp_t e;
    int   slot;
    int   n;
    logic mapped;
    slot   = int'(addr[19:16]);
    mapped = SLEN[slot];
    e.wr = wr; e.addr = addr; e.wdata = wdata; e.psel = '0;
    if (!mapped) begin
      e.rdata = DEF; e.err = 1'b1; e.lat = 0;
    end else begin
      e.psel[slot] = 1'b1;
      if (waits > TO) begin
        e.rdata = DEF; e.err = 1'b1; e.lat = TO;
      end else begin
        e.rdata = srdata; e.err = serr; e.lat = waits;
      end
    end
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    S_PREADY = '0; S_PSLVERR = '0;
    sb_q.push_back(e);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 0;
    while (1) begin
      if (mapped) begin
        S_PREADY[slot]          = (n >= waits);
        S_PSLVERR[slot]         = serr && (n >= waits);
        S_PRDATA[32*slot +: 32] = srdata;
      end
      ERR_CLR = clr_at_done && (n == e.lat);
      #1;
      if (PREADY) break;
      if (n >= 60) begin
        check_eq("xfer_bound", n, e.lat);
        break;
      end
      @(posedge PCLK); #1;
      n++;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; ERR_CLR = 1'b0; S_PREADY = '0; S_PSLVERR = '0;
  endtask

  task automatic check_err(input string tag, input logic v, input logic [1:0] c,
                           input logic w, input logic [31:0] a);
    check_eq({tag, "_valid"}, ERR_VALID, v);
    check_eq({tag, "_cause"}, ERR_CAUSE, c);
    check_eq({tag, "_write"}, ERR_WRITE, w);
    check_eq({tag, "_addr"},  ERR_ADDR,  a);
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    S_PRDATA = '0; S_PREADY = '0; S_PSLVERR = '0; S_IRQ = '0; ERR_CLR = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("rst_pready",  PREADY,  1'b1);
    check_eq("rst_pslverr", PSLVERR, 1'b0);
    check_eq("rst_prdata",  PRDATA,  32'h0);
    check_eq("rst_s_psel",  S_PSEL,  16'h0);
    check_eq("rst_pirq",    PIRQ,    16'h0);
    check_err("rst_err", 1'b0, 2'b00, 1'b0, 32'h0);

    do_xfer(1'b0, 32'h0002_0004, 32'h0, 3, 32'h1234_5678, 1'b0, 1'b0);
    check_eq("hit_no_err", ERR_VALID, 1'b0);
    do_xfer(1'b1, 32'h0003_0100, 32'hCAFE_0001, 0, 32'h0000_3333, 1'b0, 1'b0);

    do_xfer(1'b0, 32'h000C_0000, 32'h0, 0, 32'h0, 1'b0, 1'b0);
    check_err("unmapped", 1'b1, 2'b01, 1'b0, 32'h000C_0000);

    @(posedge PCLK); #1 ERR_CLR = 1'b1;
    @(posedge PCLK); #1 ERR_CLR = 1'b0;
    check_err("clr", 1'b0, 2'b00, 1'b0, 32'h0);

    do_xfer(1'b1, 32'h0006_0010, 32'h0000_0055, 100, 32'h0000_6666, 1'b0, 1'b0);
    check_err("timeout", 1'b1, 2'b10, 1'b1, 32'h0006_0010);

    do_xfer(1'b0, 32'h0006_0014, 32'h0, TO, 32'h6060_6060, 1'b0, 1'b0);
    check_err("edge_no_to", 1'b1, 2'b10, 1'b1, 32'h0006_0010);

    do_xfer(1'b1, 32'h0001_0008, 32'h0000_0011, 1, 32'h0000_0101, 1'b1, 1'b0);
    check_err("sticky", 1'b1, 2'b10, 1'b1, 32'h0006_0010);

    do_xfer(1'b0, 32'h000F_0008, 32'h0, 0, 32'h0, 1'b0, 1'b1);
    check_err("clr_and_new", 1'b1, 2'b01, 1'b0, 32'h000F_0008);

    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 32'h0002_0000;
    #1;
    check_eq("idle_pen_s_psel",  S_PSEL,  16'h0);
    check_eq("idle_pen_pready",  PREADY,  1'b1);
    check_eq("idle_pen_pslverr", PSLVERR, 1'b0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;

    @(posedge PCLK); #1 S_IRQ = 16'hFFFF;
    @(negedge PCLK);
    check_eq("pirq_latency", PIRQ, 16'h0000);
    @(negedge PCLK);
    check_eq("pirq_all", PIRQ, 16'h03FF);
    @(posedge PCLK); #1 S_IRQ = 16'h8421;
    @(negedge PCLK);
    @(negedge PCLK);
    check_eq("pirq_mask", PIRQ, 16'h0021);
    @(posedge PCLK); #1 S_IRQ = 16'hFFFF;

    // Reset in the middle of a stalled access.
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0006_0020; S_PREADY = '0;
    @(posedge PCLK); #1 PENABLE = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b1;
    @(posedge PCLK); #1 PRESET = 1'b0;
    @(negedge PCLK);
    check_eq("mid_rst_s_psel", S_PSEL,    16'h0);
    check_eq("mid_rst_valid",  ERR_VALID, 1'b0);
    check_eq("mid_rst_pirq",   PIRQ,      16'h0);
    check_eq("mid_rst_pready", PREADY,    1'b1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; S_IRQ = '0;

    do_xfer(1'b0, 32'h0006_0024, 32'h0, 100, 32'h0, 1'b0, 1'b0);
    check_err("post_rst_to", 1'b1, 2'b10, 1'b0, 32'h0006_0024);

    @(posedge PCLK);
    check_eq("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
